// File: rtl/rv32i_types.sv
// Shared RV32I types: machine word and arbiter state encoding.
// Imported by the cache arbiter and its bench.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Two-client (I/D) arbiter onto one shared memory port; D wins ties.
// Optional I-side starvation guard under macro ARB_STARVE_GUARD_EN.
module cache_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_read,
  input  rv32i_word  i_address,
  output rv32i_word  i_rdata,
  output logic       i_resp,
  input  logic       d_read,
  input  logic       d_write,
  input  logic [3:0] d_byte_enable,
  input  rv32i_word  d_address,
  input  rv32i_word  d_wdata,
  output rv32i_word  d_rdata,
  output logic       d_resp,
  output logic       mem_read,
  output logic       mem_write,
  output logic [3:0] mem_byte_enable,
  output rv32i_word  mem_address,
  output rv32i_word  mem_wdata,
  input  rv32i_word  mem_rdata,
  input  logic       mem_resp
);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  arb_state_t state_q, state_d;
  logic       rd_q, rd_d;
  logic       wr_q, wr_d;
  logic [3:0] be_q, be_d;
  rv32i_word  addr_q, addr_d;
  rv32i_word  wdata_q, wdata_d;

  logic d_req;
  logic d_win;
  logic force_i;
  logic busy;

  assign d_req = d_read | d_write;
  assign d_win = d_req & ~(force_i & i_read);
  assign busy  = (state_q != IDLE);

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign force_i = (cnt_q == CW'(STARVE_LIMIT));

  // Count IDLE arbitrations the I-side loses; clear on I grant
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && i_read) begin
      if (!d_win) begin
        cnt_d = '0;
      end else if (!force_i) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign force_i = 1'b0;
`endif

  // Next state: pick a winner in IDLE and latch its command
  always_comb begin
    state_d = state_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (d_win) begin
          state_d = SERVE_D;
          rd_d    = ~d_write;
          wr_d    = d_write;
          be_d    = d_byte_enable;
          addr_d  = d_address;
          wdata_d = d_wdata;
        end else if (i_read) begin
          state_d = SERVE_I;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          be_d    = 4'hF;
          addr_d  = i_address;
          wdata_d = '0;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and latched command registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_read        = busy & rd_q;
  assign mem_write       = busy & wr_q;
  assign mem_byte_enable = be_q;
  assign mem_address     = addr_q;
  assign mem_wdata       = wdata_q;

  assign i_resp  = mem_resp & (state_q == SERVE_I);
  assign d_resp  = mem_resp & (state_q == SERVE_D);
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: vector table, corner sequences, random vs model.
// Starvation expectations follow macro ARB_STARVE_GUARD_EN.
module tb_cache_arbiter;
  import rv32i_types::*;

  localparam int LIMIT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_read;
  rv32i_word  i_address;
  rv32i_word  i_rdata;
  logic       i_resp;
  logic       d_read;
  logic       d_write;
  logic [3:0] d_byte_enable;
  rv32i_word  d_address;
  rv32i_word  d_wdata;
  rv32i_word  d_rdata;
  logic       d_resp;
  logic       mem_read;
  logic       mem_write;
  logic [3:0] mem_byte_enable;
  rv32i_word  mem_address;
  rv32i_word  mem_wdata;
  rv32i_word  mem_rdata;
  logic       mem_resp;

  int n_vec = 0;
  int n_err = 0;

  cache_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk             (clk),
    .rst             (rst),
    .i_read          (i_read),
    .i_address       (i_address),
    .i_rdata         (i_rdata),
    .i_resp          (i_resp),
    .d_read          (d_read),
    .d_write         (d_write),
    .d_byte_enable   (d_byte_enable),
    .d_address       (d_address),
    .d_wdata         (d_wdata),
    .d_rdata         (d_rdata),
    .d_resp          (d_resp),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_address     (mem_address),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       ir;
    logic       dr;
    logic       dw;
    logic [3:0] be;
    rv32i_word  ia;
    rv32i_word  da;
    rv32i_word  wd;
    logic       xrd;
    logic       xwr;
    logic [3:0] xbe;
    rv32i_word  xa;
    rv32i_word  xwd;
    logic       ckwd;
  } vec_t;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_in();
    i_read   = 1'b0;
    d_read   = 1'b0;
    d_write  = 1'b0;
    mem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_rd"}, 32'(mem_read), 0);
    chk({nm, "_wr"}, 32'(mem_write), 0);
  endtask

  vec_t tbl[6];

  // random-phase model state
  bit        i_pend, d_pend;
  int        d_op;
  rv32i_word ri_a, rd_a, rd_wd;
  logic [3:0] rd_be;
  int        m_st;
  int        m_wait;
  int        cnt;
  logic      e_rd, e_wr;
  logic [3:0] e_be;
  rv32i_word e_a, e_wd, rdat;
  bit        gi;
  int        got;
  logic      exp_d;

  initial begin
    rst           = 1'b1;
    i_read        = 1'b1;
    i_address     = 32'h60;
    d_read        = 1'b0;
    d_write       = 1'b1;
    d_byte_enable = 4'hF;
    d_address     = 32'h100;
    d_wdata       = 32'h55;
    mem_rdata     = '0;
    mem_resp      = 1'b1;

    tbl[0] = '{1, 0, 0, 4'h0, 32'h60, 32'h1234, 32'hAAAA,
               1, 0, 4'hF, 32'h60, 32'h0, 1};
    tbl[1] = '{1, 0, 0, 4'h3, 32'hFFFFFFFC, 32'h0, 32'hFFFF,
               1, 0, 4'hF, 32'hFFFFFFFC, 32'h0, 1};
    tbl[2] = '{0, 1, 0, 4'h5, 32'h0, 32'h80, 32'h77,
               1, 0, 4'h5, 32'h80, 32'h0, 0};
    tbl[3] = '{0, 0, 1, 4'h3, 32'h0, 32'h100, 32'h12345678,
               0, 1, 4'h3, 32'h100, 32'h12345678, 1};
    tbl[4] = '{0, 1, 1, 4'hC, 32'h0, 32'h204, 32'hCAFEF00D,
               0, 1, 4'hC, 32'h204, 32'hCAFEF00D, 1};
    tbl[5] = '{0, 0, 1, 4'hF, 32'h0, 32'h0, 32'hFFFFFFFF,
               0, 1, 4'hF, 32'h0, 32'hFFFFFFFF, 1};

    // reset holds everything quiet even with requests and resp present
    step();
    smp();
    chk_idle("rst");
    chk("rst_iresp", 32'(i_resp), 0);
    chk("rst_dresp", 32'(d_resp), 0);
    chk("rst_addr", mem_address, 0);
    idle_in();
    step();
    rst = 1'b0;

    // table: lone requests at minimum latency
    for (int v = 0; v < 6; v++) begin
      step();
      i_read        = tbl[v].ir;
      i_address     = tbl[v].ia;
      d_read        = tbl[v].dr;
      d_write       = tbl[v].dw;
      d_byte_enable = tbl[v].be;
      d_address     = tbl[v].da;
      d_wdata       = tbl[v].wd;
      mem_resp      = 1'b0;
      smp();
      chk_idle($sformatf("t%0d_req", v));
      step();
      rdat      = $urandom;
      mem_rdata = rdat;
      mem_resp  = 1'b1;
      smp();
      chk($sformatf("t%0d_rd", v), 32'(mem_read), 32'(tbl[v].xrd));
      chk($sformatf("t%0d_wr", v), 32'(mem_write), 32'(tbl[v].xwr));
      chk($sformatf("t%0d_be", v), 32'(mem_byte_enable),
          32'(tbl[v].xbe));
      chk($sformatf("t%0d_addr", v), mem_address, tbl[v].xa);
      if (tbl[v].ckwd) begin
        chk($sformatf("t%0d_wd", v), mem_wdata, tbl[v].xwd);
      end
      chk($sformatf("t%0d_iresp", v), 32'(i_resp), 32'(tbl[v].ir));
      chk($sformatf("t%0d_dresp", v), 32'(d_resp),
          32'(tbl[v].dr | tbl[v].dw));
      chk($sformatf("t%0d_irdata", v), i_rdata, rdat);
      chk($sformatf("t%0d_drdata", v), d_rdata, rdat);
      step();
      idle_in();
      smp();
      chk_idle($sformatf("t%0d_after", v));
    end

    // lone I read at 0x60, memory answers on the fourth serve cycle
    step();
    i_read    = 1'b1;
    i_address = 32'h60;
    smp();
    for (int k = 0; k < 3; k++) begin
      step();
      smp();
      chk($sformatf("i60_rd%0d", k), 32'(mem_read), 1);
      chk($sformatf("i60_addr%0d", k), mem_address, 32'h60);
      chk($sformatf("i60_be%0d", k), 32'(mem_byte_enable), 32'hF);
      chk($sformatf("i60_iresp%0d", k), 32'(i_resp), 0);
    end
    step();
    mem_rdata = 32'hDEADBEEF;
    mem_resp  = 1'b1;
    smp();
    chk("i60_iresp", 32'(i_resp), 1);
    chk("i60_rdata", i_rdata, 32'hDEADBEEF);
    chk("i60_dresp", 32'(d_resp), 0);
    step();
    idle_in();
    smp();
    chk("i60_pulse", 32'(i_resp), 0);
    chk_idle("i60_end");

    // simultaneous I read and D write: D first, one IDLE, then I
    step();
    i_read        = 1'b1;
    i_address     = 32'h40;
    d_write       = 1'b1;
    d_address     = 32'h100;
    d_wdata       = 32'h12345678;
    d_byte_enable = 4'b0011;
    smp();
    step();
    mem_resp = 1'b1;
    smp();
    chk("tie_dwr", 32'(mem_write), 1);
    chk("tie_drd", 32'(mem_read), 0);
    chk("tie_daddr", mem_address, 32'h100);
    chk("tie_dwd", mem_wdata, 32'h12345678);
    chk("tie_dbe", 32'(mem_byte_enable), 32'h3);
    chk("tie_dresp", 32'(d_resp), 1);
    chk("tie_iresp0", 32'(i_resp), 0);
    step();
    d_write  = 1'b0;
    mem_resp = 1'b0;
    smp();
    chk_idle("tie_gap");
    step();
    mem_resp = 1'b1;
    smp();
    chk("tie_ird", 32'(mem_read), 1);
    chk("tie_iaddr", mem_address, 32'h40);
    chk("tie_iwd", mem_wdata, 0);
    chk("tie_iresp", 32'(i_resp), 1);
    step();
    idle_in();
    smp();
    chk_idle("tie_end");

    // D read at 0x80 keeps its address when d_address moves
    step();
    d_read        = 1'b1;
    d_address     = 32'h80;
    d_byte_enable = 4'hF;
    smp();
    step();
    smp();
    chk("hold_a1", mem_address, 32'h80);
    step();
    d_address = 32'h200;
    smp();
    chk("hold_a2", mem_address, 32'h80);
    step();
    mem_resp = 1'b1;
    smp();
    chk("hold_a3", mem_address, 32'h80);
    chk("hold_dresp", 32'(d_resp), 1);
    step();
    idle_in();
    smp();

    // spurious mem_resp in IDLE
    step();
    mem_resp = 1'b1;
    smp();
    chk("spur_iresp", 32'(i_resp), 0);
    chk("spur_dresp", 32'(d_resp), 0);
    chk_idle("spur");
    step();
    mem_resp = 1'b0;
    smp();
    chk("spur_state", 32'(dut.state_q), 32'(IDLE));

    // reset in the middle of a D write
    step();
    d_write   = 1'b1;
    d_address = 32'h300;
    d_wdata   = 32'hAA;
    smp();
    step();
    smp();
    chk("mid_wr", 32'(mem_write), 1);
    step();
    rst      = 1'b1;
    mem_resp = 1'b1;
    #1;
    chk_idle("mid_rst");
    chk("mid_dresp", 32'(d_resp), 0);
    chk("mid_state", 32'(dut.state_q), 32'(IDLE));
    chk("mid_addr", mem_address, 0);
    smp();
    chk("mid_dresp2", 32'(d_resp), 0);
    step();
    rst = 1'b0;
    idle_in();
    smp();
    chk_idle("mid_after");

    // continuous D writes and I reads: grant order
    do_reset();
    i_read        = 1'b1;
    i_address     = 32'h44;
    d_write       = 1'b1;
    d_address     = 32'h88;
    d_wdata       = 32'h99;
    d_byte_enable = 4'hF;
    got = 0;
    for (int c = 0; c < 60 && got < 10; c++) begin
      step();
      mem_resp = mem_read | mem_write;
      smp();
      if (mem_read | mem_write) begin
`ifdef ARB_STARVE_GUARD_EN
        exp_d = ((got % (LIMIT + 1)) != LIMIT);
`else
        exp_d = 1'b1;
`endif
        chk($sformatf("starve_g%0d", got), 32'(mem_write),
            32'(exp_d));
        got++;
      end
    end
    chk("starve_grants", got, 10);

    // random traffic against the arbitration model
    do_reset();
    i_pend = 0;
    d_pend = 0;
    m_st   = 0;
    m_wait = 0;
    cnt    = 0;
    for (int c = 0; c < 600; c++) begin
      step();
      if (!i_pend && $urandom_range(2) == 0) begin
        i_pend = 1;
        ri_a   = $urandom;
      end
      if (!d_pend && $urandom_range(2) == 0) begin
        d_pend = 1;
        d_op   = $urandom_range(2);
        rd_a   = $urandom;
        rd_wd  = $urandom;
        rd_be  = 4'($urandom);
      end
      i_read        = i_pend;
      i_address     = i_pend ? ri_a : rv32i_word'($urandom);
      d_read        = d_pend && d_op != 1;
      d_write       = d_pend && d_op != 0;
      d_address     = d_pend ? rd_a : rv32i_word'($urandom);
      d_wdata       = d_pend ? rd_wd : rv32i_word'($urandom);
      d_byte_enable = d_pend ? rd_be : 4'($urandom);
      rdat          = $urandom;
      mem_rdata     = rdat;
      if (m_st != 0) mem_resp = (m_wait == 0);
      else mem_resp = ($urandom_range(3) == 0);
      smp();
      if (m_st == 0) begin
        chk_idle("rnd_idle");
        chk("rnd_idle_iresp", 32'(i_resp), 0);
        chk("rnd_idle_dresp", 32'(d_resp), 0);
        if (i_pend || d_pend) begin
`ifdef ARB_STARVE_GUARD_EN
          gi = i_pend && (!d_pend || cnt == LIMIT);
          if (i_pend && d_pend && !gi && cnt < LIMIT) cnt++;
          if (gi) cnt = 0;
`else
          gi = i_pend && !d_pend;
`endif
          if (gi) begin
            m_st = 1;
            e_rd = 1;
            e_wr = 0;
            e_be = 4'hF;
            e_a  = ri_a;
            e_wd = 0;
          end else begin
            m_st = 2;
            e_wr = (d_op != 0);
            e_rd = !e_wr;
            e_be = rd_be;
            e_a  = rd_a;
            e_wd = rd_wd;
          end
          m_wait = $urandom_range(3);
        end
      end else begin
        chk("rnd_rd", 32'(mem_read), 32'(e_rd));
        chk("rnd_wr", 32'(mem_write), 32'(e_wr));
        chk("rnd_be", 32'(mem_byte_enable), 32'(e_be));
        chk("rnd_addr", mem_address, e_a);
        if (m_st == 1 || e_wr) chk("rnd_wd", mem_wdata, e_wd);
        chk("rnd_iresp", 32'(i_resp), 32'(mem_resp && m_st == 1));
        chk("rnd_dresp", 32'(d_resp), 32'(mem_resp && m_st == 2));
        if (mem_resp) begin
          chk("rnd_irdata", i_rdata, rdat);
          chk("rnd_drdata", d_rdata, rdat);
          if (m_st == 1) i_pend = 0;
          else d_pend = 0;
          m_st = 0;
        end else begin
          m_wait--;
        end
      end
    end
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
